// File: rtl/dsi_lanes_sequencer_if.sv
// Byte-stream handshake between the packet assembler and the DSI lane sequencer.
// One byte per lane per word; s_strb marks valid lanes, s_last closes the burst.
interface dsi_lanes_sequencer_if #(
  parameter int MAX_LANES = 4
);
  logic [8*MAX_LANES-1:0] s_data;
  logic [MAX_LANES-1:0]   s_strb;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;

  modport master (output s_data, s_strb, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_strb, s_valid, s_last, output s_ready);
endinterface

// File: rtl/dsi_lanes_sequencer.sv
// DSI data-lane burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11.
// Optional ULPS escape entry/exit is built when DSI_LANES_SEQUENCER_ULPS_EN is defined.
module dsi_lanes_sequencer #(
  parameter int MAX_LANES = 4,
  parameter int CNT_W     = 8,
  parameter int LN_W      = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   lines_enable,
  input  logic                   clk_lane_ready,
  input  logic [LN_W-1:0]        cfg_lanes,
  input  logic [CNT_W-1:0]       cfg_t_lpx,
  input  logic [CNT_W-1:0]       cfg_t_hs_prepare,
  input  logic [CNT_W-1:0]       cfg_t_hs_zero,
  input  logic [CNT_W-1:0]       cfg_t_hs_trail,
  input  logic [CNT_W-1:0]       cfg_t_hs_exit,
  dsi_lanes_sequencer_if.slave   s,
  output logic [8*MAX_LANES-1:0] hs_data,
  output logic [MAX_LANES-1:0]   hs_en,
  output logic [MAX_LANES-1:0]   lp_p,
  output logic [MAX_LANES-1:0]   lp_n,
  output logic [MAX_LANES-1:0]   lp_oe,
  output logic                   busy,
  output logic                   err_underflow
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
  ,
  input  logic                   ulps_rqst,
  output logic                   ulps_active
`endif
);

  localparam int CW = CNT_W + 8;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL, ST_EXIT
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    , ST_ESC, ST_HOLD, ST_MARK
`endif
  } state_t;

  state_t                 r_state, w_next;
  logic [CW-1:0]          r_cnt, w_dur;
  logic                   w_done, w_accept;
  logic [LN_W-1:0]        r_lanes;
  logic [CNT_W-1:0]       r_t_lpx, r_t_prep, r_t_zero, r_t_trail, r_t_exit;
  logic [MAX_LANES-1:0]   r_last_msb, w_act;
  logic [8*MAX_LANES-1:0] w_hs_data;
  logic [MAX_LANES-1:0]   w_hs_en, w_lp_p, w_lp_n, w_lp_oe;
  logic                   w_err;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
  localparam logic [7:0] ULPS_CMD = 8'h1E;
  logic [4:0]             r_step;
  logic                   w_ulps;
`endif

  function automatic logic [LN_W-1:0] sat_lanes(input logic [LN_W-1:0] v);
    if (int'(v) > MAX_LANES - 1) return LN_W'(MAX_LANES - 1);
    return v;
  endfunction

  function automatic logic [CW-1:0] phase_len(input logic [CNT_W-1:0] t);
    return (t == '0) ? CW'(1) : CW'(t);
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [LN_W-1:0] n);
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) m[i] = (i <= int'(n));
    return m;
  endfunction

  // Trail level is the inverse of the final serialized bit (MSB, sent last).
  function automatic logic [7:0] trail_byte(input logic msb);
    return msb ? 8'h00 : 8'hFF;
  endfunction

`ifdef DSI_LANES_SEQUENCER_ULPS_EN
  // Steps 0-3: escape entry; steps 4-19: spaced-one-hot ULPS command, MSB first.
  function automatic logic [1:0] esc_level(input logic [4:0] step);
    logic [2:0] k;
    if (step < 5'd4) begin
      case (step[1:0])
        2'd0:    return 2'b10;
        2'd2:    return 2'b01;
        default: return 2'b00;
      endcase
    end
    if (step[0]) return 2'b00;
    k = 3'((step - 5'd4) >> 1);
    return ULPS_CMD[3'd7 - k] ? 2'b10 : 2'b01;
  endfunction
`endif

  // Outside IDLE the lane set is frozen at burst start.
  assign w_act     = lane_mask((r_state == ST_IDLE) ? sat_lanes(cfg_lanes) : r_lanes);
  assign w_accept  = (r_state == ST_DATA) && s.s_valid;
  assign w_done    = (r_cnt >= w_dur - CW'(1));
  assign s.s_ready = (r_state == ST_DATA);
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_dur = CW'(1);
    case (r_state)
      ST_LPX:   w_dur = phase_len(r_t_lpx);
      ST_PREP:  w_dur = phase_len(r_t_prep);
      ST_ZERO:  w_dur = phase_len(r_t_zero);
      ST_TRAIL: w_dur = phase_len(r_t_trail);
      ST_EXIT:  w_dur = phase_len(r_t_exit);
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      ST_ESC:   w_dur = phase_len(r_t_lpx);
      ST_MARK:  w_dur = phase_len(r_t_lpx) << 8;
`endif
      default:  w_dur = CW'(1);
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      r_step  <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CW'(1);
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      if (r_state == ST_IDLE) r_step <= '0;
      else if (r_state == ST_ESC && w_done) begin
        r_cnt  <= '0;
        r_step <= r_step + 5'd1;
      end
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
        if (ulps_rqst) w_next = ST_ESC; else
`endif
        if (s.s_valid && clk_lane_ready && lines_enable) w_next = ST_LPX;
      end
      ST_LPX:   if (w_done) w_next = ST_PREP;
      ST_PREP:  if (w_done) w_next = ST_ZERO;
      ST_ZERO:  if (w_done) w_next = ST_SYNC;
      ST_SYNC:  w_next = ST_DATA;
      ST_DATA:  if (!s.s_valid || s.s_last) w_next = ST_TRAIL;
      ST_TRAIL: if (w_done) w_next = ST_EXIT;
      ST_EXIT:  if (w_done) w_next = ST_IDLE;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      ST_ESC:   if (w_done && r_step == 5'd19) w_next = ST_HOLD;
      ST_HOLD:  if (!ulps_rqst) w_next = ST_MARK;
      ST_MARK:  if (w_done) w_next = ST_IDLE;
`endif
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (r_state == ST_IDLE && w_next != ST_IDLE) begin
      r_lanes   <= sat_lanes(cfg_lanes);
      r_t_lpx   <= cfg_t_lpx;
      r_t_prep  <= cfg_t_hs_prepare;
      r_t_zero  <= cfg_t_hs_zero;
      r_t_trail <= cfg_t_hs_trail;
      r_t_exit  <= cfg_t_hs_exit;
    end
    if (r_state == ST_SYNC) r_last_msb <= '1;
    else if (w_accept) begin
      for (int i = 0; i < MAX_LANES; i++)
        if (s.s_strb[i]) r_last_msb[i] <= s.s_data[8*i+7];
    end
  end

  always_comb begin
    w_hs_data = '0;
    w_hs_en   = '0;
    w_lp_p    = '1;
    w_lp_n    = '1;
    w_lp_oe   = w_act & {MAX_LANES{lines_enable}};
    w_err     = 1'b0;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    w_ulps    = 1'b0;
`endif
    if (r_state inside {ST_LPX, ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL}) w_lp_p = ~w_act;
    if (r_state inside {ST_PREP, ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL})         w_lp_n = ~w_act;
    if (r_state inside {ST_ZERO, ST_SYNC, ST_DATA, ST_TRAIL})                  w_hs_en = w_act;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (w_act[i]) begin
        case (r_state)
          ST_SYNC:  w_hs_data[8*i +: 8] = 8'hB8;
          ST_DATA:  w_hs_data[8*i +: 8] = (w_accept && s.s_strb[i]) ? s.s_data[8*i +: 8]
                                                                     : trail_byte(r_last_msb[i]);
          ST_TRAIL: w_hs_data[8*i +: 8] = trail_byte(r_last_msb[i]);
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
          ST_ESC:   {w_lp_p[i], w_lp_n[i]} = esc_level(r_step);
          ST_HOLD:  {w_lp_p[i], w_lp_n[i]} = 2'b00;
          ST_MARK:  w_lp_n[i] = 1'b0;
`endif
          default:  ;
        endcase
      end
    end
    if (r_state == ST_DATA && !s.s_valid) w_err = 1'b1;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    if (r_state == ST_HOLD) w_ulps = 1'b1;
`endif
  end

  // Pin register stage: pins trail the state by one cycle.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      hs_data       <= '0;
      hs_en         <= '0;
      lp_p          <= '1;
      lp_n          <= '1;
      lp_oe         <= '0;
      err_underflow <= 1'b0;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      ulps_active   <= 1'b0;
`endif
    end else begin
      hs_data       <= w_hs_data;
      hs_en         <= w_hs_en;
      lp_p          <= w_lp_p;
      lp_n          <= w_lp_n;
      lp_oe         <= w_lp_oe;
      err_underflow <= w_err;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
      ulps_active   <= w_ulps;
`endif
    end
  end

endmodule

// File: tb/tb_dsi_lanes_sequencer.sv
// Bench for dsi_lanes_sequencer: bursts are checked pin-by-pin against a phase-list model
// built from the burst rules; ULPS checks are compiled only with DSI_LANES_SEQUENCER_ULPS_EN.
module tb_dsi_lanes_sequencer;
  localparam int ML = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n, lines_enable, clk_lane_ready;
  logic [1:0]  cfg_lanes;
  logic [7:0]  cfg_t_lpx, cfg_t_hs_prepare, cfg_t_hs_zero, cfg_t_hs_trail, cfg_t_hs_exit;
  logic [31:0] hs_data;
  logic [3:0]  hs_en, lp_p, lp_n, lp_oe;
  logic        busy, err_underflow;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
  logic        ulps_rqst, ulps_active;
`endif

  dsi_lanes_sequencer_if #(.MAX_LANES(ML)) sif ();

  dsi_lanes_sequencer #(.MAX_LANES(ML), .CNT_W(8)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .lines_enable(lines_enable),
    .clk_lane_ready(clk_lane_ready), .cfg_lanes(cfg_lanes),
    .cfg_t_lpx(cfg_t_lpx), .cfg_t_hs_prepare(cfg_t_hs_prepare),
    .cfg_t_hs_zero(cfg_t_hs_zero), .cfg_t_hs_trail(cfg_t_hs_trail),
    .cfg_t_hs_exit(cfg_t_hs_exit), .s(sif),
    .hs_data(hs_data), .hs_en(hs_en), .lp_p(lp_p), .lp_n(lp_n), .lp_oe(lp_oe),
    .busy(busy), .err_underflow(err_underflow)
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    , .ulps_rqst(ulps_rqst), .ulps_active(ulps_active)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [3:0]  p;
    logic [3:0]  n;
    logic [3:0]  oe;
    logic [3:0]  en;
    logic [31:0] d;
    logic        err;
  } frame_t;

  frame_t      exp_q[$], obs_q[$];
  logic [31:0] wd[$];
  logic [3:0]  ws[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          busy_cnt;

  function automatic int eff(input logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  task automatic set_cfg(input int ln, input int a, input int b, input int c, input int e, input int f);
    cfg_lanes = 2'(ln); cfg_t_lpx = 8'(a); cfg_t_hs_prepare = 8'(b);
    cfg_t_hs_zero = 8'(c); cfg_t_hs_trail = 8'(e); cfg_t_hs_exit = 8'(f);
  endtask

  // Expected pin frames, one per cycle, from the first LPX cycle to the first IDLE cycle.
  task automatic build_expected(input int uf);
    logic [3:0]  act, msb;
    logic [31:0] d;
    frame_t      f;
    int          lim;
    exp_q.delete();
    act = 4'((1 << (int'(cfg_lanes) + 1)) - 1);
    lim = (uf < wd.size()) ? uf : wd.size();
    repeat (eff(cfg_t_lpx))        begin f = {~act, 4'hF, act, 4'h0, 32'h0, 1'b0}; exp_q.push_back(f); end
    repeat (eff(cfg_t_hs_prepare)) begin f = {~act, ~act, act, 4'h0, 32'h0, 1'b0}; exp_q.push_back(f); end
    repeat (eff(cfg_t_hs_zero))    begin f = {~act, ~act, act, act, 32'h0, 1'b0}; exp_q.push_back(f); end
    d = '0;
    for (int i = 0; i < ML; i++) if (act[i]) d[8*i +: 8] = 8'hB8;
    msb = 4'hF;
    f = {~act, ~act, act, act, d, 1'b0}; exp_q.push_back(f);
    for (int k = 0; k < lim; k++) begin
      d = '0;
      for (int i = 0; i < ML; i++) begin
        if (act[i] && ws[k][i]) begin d[8*i +: 8] = wd[k][8*i +: 8]; msb[i] = wd[k][8*i+7]; end
        else if (act[i]) d[8*i +: 8] = msb[i] ? 8'h00 : 8'hFF;
      end
      f = {~act, ~act, act, act, d, 1'b0}; exp_q.push_back(f);
    end
    d = '0;
    for (int i = 0; i < ML; i++) if (act[i]) d[8*i +: 8] = msb[i] ? 8'h00 : 8'hFF;
    if (uf < wd.size()) begin f = {~act, ~act, act, act, d, 1'b1}; exp_q.push_back(f); end
    repeat (eff(cfg_t_hs_trail))   begin f = {~act, ~act, act, act, d, 1'b0}; exp_q.push_back(f); end
    repeat (eff(cfg_t_hs_exit) + 1) begin f = {4'hF, 4'hF, act, 4'h0, 32'h0, 1'b0}; exp_q.push_back(f); end
  endtask

  // Streams wd/ws (stopping after uf words) and records one pin frame per cycle.
  task automatic run_burst(input int uf);
    int lim;
    lim = (uf < wd.size()) ? uf : wd.size();
    obs_q.delete();
    busy_cnt = 0;
    sif.s_data = wd[0]; sif.s_strb = ws[0]; sif.s_last = (wd.size() == 1); sif.s_valid = 1'b1;
    fork
      begin
        int   w;
        logic acc;
        w = 0;
        for (int c = 0; c < 400 && sif.s_valid; c++) begin
          @(negedge clk_sys); acc = sif.s_valid && sif.s_ready;
          @(posedge clk_sys); #1;
          if (acc) begin
            w++;
            if (w >= lim) sif.s_valid = 1'b0;
            else begin sif.s_data = wd[w]; sif.s_strb = ws[w]; sif.s_last = (w == wd.size() - 1); end
          end
        end
        sif.s_valid = 1'b0;
      end
      begin
        @(posedge clk_sys);
        for (int j = 0; j <= exp_q.size(); j++) begin
          @(negedge clk_sys);
          busy_cnt += int'(busy);
          if (j > 0) obs_q.push_back({lp_p, lp_n, lp_oe, hs_en, hs_data, err_underflow});
        end
      end
    join
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    n_assert++;
    if ({lp_p, lp_n, lp_oe, hs_en, hs_data, err_underflow} !== {4'hF, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_pins: got %h want %h", {lp_p, lp_n, lp_oe, hs_en, hs_data, err_underflow},
                         {4'hF, 4'hF, 4'h0, 4'h0, 32'h0, 1'b0});
    end
    n_assert++;
    if ({busy, sif.s_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00", {busy, sif.s_ready}); end
    rst_n = 1'b1;
    @(posedge clk_sys); @(negedge clk_sys);
    n_assert++;
    if (lp_oe !== 4'hF) begin n_fail++; $display("FAIL idle_lp_oe: got %h want f", lp_oe); end
  endtask

  task automatic test_idle_block();
    lines_enable = 1'b0; sif.s_valid = 1'b1;
    repeat (4) @(negedge clk_sys);
    n_assert++;
    if ({busy, lp_oe} !== 5'b0_0000) begin n_fail++; $display("FAIL no_lines_enable: got %b want 00000", {busy, lp_oe}); end
    lines_enable = 1'b1; clk_lane_ready = 1'b0;
    repeat (4) @(negedge clk_sys);
    n_assert++;
    if ({busy, lp_oe} !== 5'b0_1111) begin n_fail++; $display("FAIL no_clk_ready: got %b want 01111", {busy, lp_oe}); end
    sif.s_valid = 1'b0; clk_lane_ready = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic test_basic();
    set_cfg(3, 3, 2, 5, 4, 3);
    wd = '{32'h44332211}; ws = '{4'hF};
    build_expected(99); run_burst(99);
    foreach (exp_q[k]) begin
      n_assert++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL basic frame %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_assert++;
    if (busy_cnt !== 19) begin n_fail++; $display("FAIL basic_busy: got %0d want 19", busy_cnt); end
    n_assert++;
    if ({obs_q[10].d, obs_q[11].d, obs_q[12].d} !== {32'hB8B8B8B8, 32'h44332211, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL basic_bytes: got %h %h %h want b8b8b8b8 44332211 ffffffff", obs_q[10].d, obs_q[11].d, obs_q[12].d);
    end
  endtask

  task automatic test_lanes();
    logic [7:0] t1;
    set_cfg(1, 3, 2, 5, 4, 3);
    wd = '{$urandom, $urandom, $urandom}; ws = '{4'hF, 4'hF, 4'h1};
    build_expected(99); run_burst(99);
    foreach (exp_q[k]) begin
      n_assert++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL lanes frame %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_assert++;
    if (obs_q[5].en !== 4'b0011) begin n_fail++; $display("FAIL lanes_hs_en: got %b want 0011", obs_q[5].en); end
    t1 = wd[1][15] ? 8'h00 : 8'hFF;
    n_assert++;
    if (obs_q[13].d[15:0] !== {t1, wd[2][7:0]}) begin
      n_fail++; $display("FAIL lanes_short_last: got %h want %h", obs_q[13].d[15:0], {t1, wd[2][7:0]});
    end
  endtask

  task automatic test_trail_msb();
    set_cfg(1, 3, 2, 5, 2, 1);
    wd = '{32'h0000_7F80}; ws = '{4'hF};
    build_expected(99); run_burst(99);
    foreach (exp_q[k]) begin
      n_assert++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL trail frame %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_assert++;
    if (obs_q[12].d[15:0] !== 16'hFF00) begin n_fail++; $display("FAIL trail_msb: got %h want ff00", obs_q[12].d[15:0]); end
  endtask

  task automatic test_underflow();
    int errs;
    set_cfg(3, 3, 2, 5, 4, 3);
    wd = '{$urandom, $urandom, $urandom, $urandom, $urandom}; ws = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    build_expected(2); run_burst(2);
    errs = 0;
    foreach (exp_q[k]) begin
      errs += int'(obs_q[k].err);
      n_assert++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL underflow frame %0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    n_assert++;
    if (errs !== 1 || obs_q[13].err !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse: got %0d pulses want 1 at frame 13", errs); end
  endtask

  task automatic test_random();
    int nw, uf;
    for (int it = 0; it < 8; it++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      nw = $urandom_range(1, 4);
      wd.delete(); ws.delete();
      for (int k = 0; k < nw; k++) begin
        wd.push_back($urandom);
        ws.push_back((k == nw - 1) ? 4'((1 << $urandom_range(1, 4)) - 1) : 4'hF);
      end
      uf = (nw > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nw - 1) : 99;
      build_expected(uf); run_burst(uf);
      foreach (exp_q[k]) begin
        n_assert++;
        if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL random%0d frame %0d: got %h want %h", it, k, obs_q[k], exp_q[k]); end
      end
      n_assert++;
      if (busy_cnt !== exp_q.size() - 1) begin n_fail++; $display("FAIL random%0d busy: got %0d want %0d", it, busy_cnt, exp_q.size() - 1); end
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(3, 3, 2, 5, 4, 3);
    sif.s_data = 32'hA5A5A5A5; sif.s_strb = 4'hF; sif.s_last = 1'b1; sif.s_valid = 1'b1;
    @(posedge clk_sys);
    repeat (6) @(posedge clk_sys);
    @(negedge clk_sys);
    n_assert++;
    if (hs_en !== 4'hF) begin n_fail++; $display("FAIL mid_hs_zero: got hs_en %h want f", hs_en); end
    rst_n = 1'b0; sif.s_valid = 1'b0;
    @(negedge clk_sys);
    n_assert++;
    if ({hs_en, lp_p, lp_n, lp_oe, busy} !== {4'h0, 4'hF, 4'hF, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got %h want %h", {hs_en, lp_p, lp_n, lp_oe, busy}, {4'h0, 4'hF, 4'hF, 4'h0, 1'b0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

`ifdef DSI_LANES_SEQUENCER_ULPS_EN
  task automatic test_ulps();
    logic [1:0] useq[20];
    logic [7:0] cmd;
    int         marks;
    cmd = 8'h1E;
    useq[0] = 2'b10; useq[1] = 2'b00; useq[2] = 2'b01; useq[3] = 2'b00;
    for (int b = 0; b < 8; b++) begin
      useq[4 + 2*b] = cmd[7 - b] ? 2'b10 : 2'b01;
      useq[5 + 2*b] = 2'b00;
    end
    set_cfg(0, 1, 2, 5, 4, 3);
    ulps_rqst = 1'b1;
    @(posedge clk_sys);
    for (int j = 0; j <= 21; j++) begin
      @(negedge clk_sys);
      if (j >= 1 && j <= 20) begin
        n_assert++;
        if ({lp_p[0], lp_n[0]} !== useq[j-1]) begin n_fail++; $display("FAIL ulps_seq %0d: got %b want %b", j - 1, {lp_p[0], lp_n[0]}, useq[j-1]); end
      end
    end
    n_assert++;
    if ({lp_p[0], lp_n[0], ulps_active} !== 3'b001) begin n_fail++; $display("FAIL ulps_hold: got %b want 001", {lp_p[0], lp_n[0], ulps_active}); end
    ulps_rqst = 1'b0;
    marks = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_sys);
      if ({lp_p[0], lp_n[0]} == 2'b11) break;
      if ({lp_p[0], lp_n[0]} == 2'b10) marks++;
    end
    n_assert++;
    if (marks !== 256 || ulps_active !== 1'b0) begin n_fail++; $display("FAIL ulps_exit: got %0d mark cycles active %b want 256 0", marks, ulps_active); end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; lines_enable = 1'b1; clk_lane_ready = 1'b1;
    set_cfg(3, 3, 2, 5, 4, 3);
    sif.s_data = '0; sif.s_strb = '0; sif.s_valid = 1'b0; sif.s_last = 1'b0;
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    ulps_rqst = 1'b0;
`endif
    test_reset();
    test_idle_block();
    test_basic();
    test_lanes();
    test_trail_msb();
    test_underflow();
    test_random();
    test_reset_mid();
`ifdef DSI_LANES_SEQUENCER_ULPS_EN
    test_ulps();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
